// File: rtl/neuron_accumulator.sv
// neuron_accumulator
// Accumulates CHUNKS signed partial sums per output neuron, adds a bias taken
// on chunk 0, saturates to DATA_W, applies the activation and stores the result
// in a NEURONS-entry buffer. A full buffer is offered with a valid/ready
// handshake, and input is stalled until the buffer is accepted.
//
// Optional feature macro: NEURON_ACC_RELU_EN
//   defined   -> activation is ReLU (negative results written as 0)
//   undefined -> activation is identity (signed saturated result written)
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   in_valid     in   psum valid this cycle
//   in_ready     out  block can accept a psum (ACCUM state)
//   psum         in   signed partial sum [DATA_W]
//   bias         in   signed bias [DATA_W], sampled on chunk 0 only
//   out_valid    out  out_neurons holds a full buffer (DRAIN state)
//   out_ready    in   consumer accepts the buffer
//   out_neurons  out  packed [NEURONS-1:0][DATA_W-1:0], entry i is neuron i
//   chunk_idx    out  index of the next chunk expected
//   neuron_idx   out  buffer slot currently being accumulated

module neuron_accumulator #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned NEURONS = 16,
    parameter int unsigned CHUNKS  = 4,
    localparam int unsigned CIDX_W = (CHUNKS  > 1) ? $clog2(CHUNKS)  : 1,
    localparam int unsigned NIDX_W = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                psum,
    input  logic [DATA_W-1:0]                bias,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NEURONS-1:0][DATA_W-1:0]   out_neurons,
    output logic [CIDX_W-1:0]                chunk_idx,
    output logic [NIDX_W-1:0]                neuron_idx
);

    localparam int unsigned EXT_W = ACC_W - DATA_W;

    // Saturation bounds expressed at accumulator width
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(EXT_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(EXT_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic                             r_in_ready;
    logic                             r_out_valid;
    logic signed [ACC_W-1:0]          r_acc;
    logic [CIDX_W-1:0]                r_chunk_idx;
    logic [NIDX_W-1:0]                r_neuron_idx;
    logic [NEURONS-1:0][DATA_W-1:0]   r_out_neurons;

    logic                             w_accept;
    logic                             w_last_chunk;
    logic                             w_last_neuron;
    logic signed [ACC_W-1:0]          w_psum_ext;
    logic signed [ACC_W-1:0]          w_bias_ext;
    logic signed [ACC_W-1:0]          w_sum;
    logic [DATA_W-1:0]                w_sat;
    logic [DATA_W-1:0]                w_act;

    assign w_accept      = in_valid && r_in_ready;
    assign w_last_chunk  = (r_chunk_idx  == CIDX_W'(CHUNKS - 1));
    assign w_last_neuron = (r_neuron_idx == NIDX_W'(NEURONS - 1));

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM: if (w_accept && w_last_chunk && w_last_neuron) w_state_nxt = DRAIN;
            DRAIN: if (out_ready) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    // State register; handshake flags registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ACCUM);
            r_out_valid <= (w_state_nxt == DRAIN);
        end
    end

    // Chunk 0 starts from the bias, so CHUNKS==1 needs no special case
    always_comb begin
        w_psum_ext = {{EXT_W{psum[DATA_W-1]}}, psum};
        w_bias_ext = {{EXT_W{bias[DATA_W-1]}}, bias};
        w_sum      = ((r_chunk_idx == '0) ? w_bias_ext : r_acc) + w_psum_ext;
        if (w_sum > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end else begin
            w_sat = w_sum[DATA_W-1:0];
        end
`ifdef NEURON_ACC_RELU_EN
        w_act = w_sat[DATA_W-1] ? '0 : w_sat;
`else
        w_act = w_sat;
`endif
    end

    // Accumulator, indices and output buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc         <= '0;
            r_chunk_idx   <= '0;
            r_neuron_idx  <= '0;
            r_out_neurons <= '0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            if (w_last_chunk) begin
                r_chunk_idx                  <= '0;
                r_out_neurons[r_neuron_idx]  <= w_act;
                r_neuron_idx <= w_last_neuron ? '0 : r_neuron_idx + NIDX_W'(1);
            end else begin
                r_chunk_idx <= r_chunk_idx + CIDX_W'(1);
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_neurons = r_out_neurons;
    assign chunk_idx   = r_chunk_idx;
    assign neuron_idx  = r_neuron_idx;

endmodule
